// File: rtl/tnbuf_seq_pkg.sv
// Shared types, width helper and parameter range checks for the tristate bus sequencer.
package tnbuf_seq_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StDrive,
      StDead
   } state_e;

   localparam int unsigned MinNch        = 2;
   localparam int unsigned MaxNch        = 16;
   localparam int unsigned MinDeadCycles = 1;
   localparam int unsigned MaxHoldLimit  = 65535;

   // Bits needed to hold any value in 0..max_val, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic bit nch_ok(input int unsigned n);
      return (n >= MinNch) && (n <= MaxNch);
   endfunction

   function automatic bit dead_cycles_ok(input int unsigned d);
      return d >= MinDeadCycles;
   endfunction

   function automatic bit max_hold_ok(input int unsigned m);
      return m <= MaxHoldLimit;
   endfunction

endpackage

// File: rtl/tnbuf_bus_sequencer_if.sv
// Request/grant bundle between the requesters (master) and the bus sequencer (slave).
interface tnbuf_bus_sequencer_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NCH   = 4
);
   import tnbuf_seq_pkg::*;

   localparam int unsigned IdxW = cnt_width(NCH - 1);

   logic [NCH-1:0]       REQ;
   logic [NCH*WIDTH-1:0] DIN;
   logic [NCH-1:0]       GNT;
   logic [NCH-1:0]       ENB;
   logic [IdxW-1:0]      OWNER;
   logic                 BUSY;

   modport master (
      output REQ,
      output DIN,
      input  GNT,
      input  ENB,
      input  OWNER,
      input  BUSY
   );

   modport slave (
      input  REQ,
      input  DIN,
      output GNT,
      output ENB,
      output OWNER,
      output BUSY
   );

endinterface

// File: rtl/tnbuf_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_i, wrapping, so last_i
// itself is considered only after every other channel.
module tnbuf_rr_arbiter #(
   parameter int unsigned NCH  = 4,
   parameter int unsigned IdxW = 2
) (
   input  logic [NCH-1:0]  req_i,
   input  logic [IdxW-1:0] last_i,
   output logic            valid_o,
   output logic [NCH-1:0]  onehot_o,
   output logic [IdxW-1:0] idx_o
);

   int unsigned cand;

   always_comb begin
      valid_o  = 1'b0;
      onehot_o = '0;
      idx_o    = '0;
      cand     = 0;
      for (int unsigned off = 1; off <= NCH; off++) begin
         cand = (32'(last_i) + off) % NCH;
         if (!valid_o && req_i[IdxW'(cand)]) begin
            valid_o                 = 1'b1;
            onehot_o[IdxW'(cand)]   = 1'b1;
            idx_o                   = IdxW'(cand);
         end
      end
   end

endmodule

// File: rtl/tnbuf_bus_sequencer.sv
// Multi-channel tristate bus driver with round-robin ownership, hold limit and dead time.
// Define TNBUF_SEQ_KEEPER_EN to add a weak keeper that holds the last driven value on Z.
module tnbuf_bus_sequencer
   import tnbuf_seq_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned NCH         = 4,
   parameter int unsigned DEAD_CYCLES = 2,
   parameter int unsigned MAX_HOLD    = 0
) (
   input  logic                       CLK,
   input  logic                       RSTB,
   tnbuf_bus_sequencer_if.slave       bus,
   inout  wire  [WIDTH-1:0]           Z
);

   localparam int unsigned IdxW  = cnt_width(NCH - 1);
   localparam int unsigned HoldW = cnt_width(MAX_HOLD);
   localparam int unsigned DeadW = cnt_width(DEAD_CYCLES);

   localparam logic [HoldW-1:0] HoldLim  = HoldW'(MAX_HOLD);
   localparam logic [HoldW-1:0] HoldSat  = (MAX_HOLD == 0) ? '1 : HoldW'(MAX_HOLD);
   localparam logic [DeadW-1:0] DeadInit = DeadW'(DEAD_CYCLES);

   if (!nch_ok(NCH) || !dead_cycles_ok(DEAD_CYCLES) || !max_hold_ok(MAX_HOLD)) begin : gen_param_err
      $error("tnbuf_bus_sequencer: parameter out of range");
   end

   state_e           state_q, state_d;
   logic [IdxW-1:0]  owner_q, owner_d;
   logic [NCH-1:0]   gnt_q, gnt_d;
   logic [HoldW-1:0] hold_q, hold_d;
   logic [DeadW-1:0] dead_q, dead_d;

   logic             arb_valid;
   logic [NCH-1:0]   arb_onehot;
   logic [IdxW-1:0]  arb_idx;
   logic             owner_req;
   logic             other_req;
   logic             hold_hit;
   logic             bus_en;
   logic [WIDTH-1:0] bus_data;

   tnbuf_rr_arbiter #(
      .NCH  (NCH),
      .IdxW (IdxW)
   ) u_arb (
      .req_i    (bus.REQ),
      .last_i   (owner_q),
      .valid_o  (arb_valid),
      .onehot_o (arb_onehot),
      .idx_o    (arb_idx)
   );

   assign owner_req = bus.REQ[owner_q];
   assign other_req = |(bus.REQ & ~gnt_q);
   assign hold_hit  = (MAX_HOLD != 0) && (hold_q == HoldLim) && other_req;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      gnt_d   = gnt_q;
      hold_d  = hold_q;
      dead_d  = dead_q;
      unique case (state_q)
         StIdle: begin
            if (arb_valid) begin
               state_d = StDrive;
               owner_d = arb_idx;
               gnt_d   = arb_onehot;
               hold_d  = HoldW'(1);
            end
         end
         StDrive: begin
            // A simultaneous request drop and hold-limit hit still yields one dead interval.
            if (!owner_req || hold_hit) begin
               state_d = StDead;
               gnt_d   = '0;
               hold_d  = '0;
               dead_d  = DeadInit;
            end else if (hold_q != HoldSat) begin
               hold_d = hold_q + HoldW'(1);
            end
         end
         StDead: begin
            if (dead_q == DeadW'(1)) begin
               dead_d = '0;
               if (arb_valid) begin
                  state_d = StDrive;
                  owner_d = arb_idx;
                  gnt_d   = arb_onehot;
                  hold_d  = HoldW'(1);
               end else begin
                  state_d = StIdle;
               end
            end else begin
               dead_d = dead_q - DeadW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         state_q <= StIdle;
         owner_q <= IdxW'(NCH - 1);
         gnt_q   <= '0;
         hold_q  <= '0;
         dead_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         gnt_q   <= gnt_d;
         hold_q  <= hold_d;
         dead_q  <= dead_d;
      end
   end

   assign bus.GNT   = gnt_q;
   assign bus.ENB   = gnt_q;
   assign bus.OWNER = owner_q;
   assign bus.BUSY  = (state_q != StIdle);

   // Grant is one-hot, so an AND-OR mux is the union of the per-channel buffers.
   always_comb begin
      bus_data = '0;
      for (int i = 0; i < NCH; i++) begin
         if (gnt_q[i]) begin
            bus_data = bus_data | bus.DIN[i*WIDTH +: WIDTH];
         end
      end
   end

   assign bus_en = |gnt_q;
   assign Z      = bus_en ? bus_data : {WIDTH{1'bz}};

`ifdef TNBUF_SEQ_KEEPER_EN
   logic [WIDTH-1:0] keeper_q, keeper_d;

   assign keeper_d = (state_q == StDrive) ? bus_data : keeper_q;

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         keeper_q <= '0;
      end else begin
         keeper_q <= keeper_d;
      end
   end

   assign (weak0, weak1) Z = bus_en ? {WIDTH{1'bz}} : keeper_q;
`else
`endif

endmodule

// File: tb/tb_tnbuf_bus_sequencer.sv
// Directed bench for tnbuf_bus_sequencer: grant/release timing, rotation, hold limit, async reset.
module tb_tnbuf_bus_sequencer;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned NCH   = 4;
   localparam int unsigned DEAD  = 2;
   localparam int unsigned HOLD  = 3;

   logic clk;
   logic rstb;
   wire [WIDTH-1:0] z;

   int checks = 0;
   int errors = 0;

   tnbuf_bus_sequencer_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

   tnbuf_bus_sequencer #(
      .WIDTH       (WIDTH),
      .NCH         (NCH),
      .DEAD_CYCLES (DEAD),
      .MAX_HOLD    (HOLD)
   ) dut (
      .CLK  (clk),
      .RSTB (rstb),
      .bus  (bus),
      .Z    (z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      bus.REQ = '0;
      rstb    = 1'b0;
      repeat (2) @(negedge clk);
      rstb = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.REQ = '0;
      bus.DIN = {8'h44, 8'h33, 8'h22, 8'h11};
      rstb    = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.ENB !== 4'b0000) begin
         errors++; $display("FAIL reset_enb got %b want 0000", bus.ENB);
      end
      checks++;
      if (bus.GNT !== 4'b0000) begin
         errors++; $display("FAIL reset_gnt got %b want 0000", bus.GNT);
      end
      checks++;
      if (bus.OWNER !== 2'd3) begin
         errors++; $display("FAIL reset_owner got %0d want 3", bus.OWNER);
      end
      checks++;
      if (bus.BUSY !== 1'b0) begin
         errors++; $display("FAIL reset_busy got %b want 0", bus.BUSY);
      end
      rstb = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.BUSY !== 1'b0) begin
         errors++; $display("FAIL idle_busy got %b want 0", bus.BUSY);
      end
   endtask

   task automatic test_single();
      logic [3:0] exp_enb;
      logic       exp_busy;
      bus.DIN[7:0] = 8'hA5;
      bus.REQ      = 4'b0001;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         exp_enb  = (c <= 5) ? 4'b0001 : 4'b0000;
         exp_busy = (c <= 7);
         checks++;
         if (bus.ENB !== exp_enb) begin
            errors++; $display("FAIL single_enb c%0d got %b want %b", c, bus.ENB, exp_enb);
         end
         checks++;
         if (bus.BUSY !== exp_busy) begin
            errors++; $display("FAIL single_busy c%0d got %b want %b", c, bus.BUSY, exp_busy);
         end
         if (c <= 5) begin
            checks++;
            if (z !== 8'hA5) begin
               errors++; $display("FAIL single_z c%0d got %h want a5", c, z);
            end
         end
         if (c == 5) bus.REQ = 4'b0000;
      end
      checks++;
      if (bus.OWNER !== 2'd0) begin
         errors++; $display("FAIL single_owner got %0d want 0", bus.OWNER);
      end
   endtask

   task automatic test_rotation();
      logic [3:0] exp_enb;
      logic [7:0] exp_z;
      int         slot;
      int         ph;
      do_reset();
      bus.DIN = {8'h44, 8'h33, 8'h22, 8'h11};
      bus.REQ = 4'b1111;
      // Each owner: 3 drive cycles then 2 dead cycles; owners 0,1,2,3,0.
      for (int c = 1; c <= 23; c++) begin
         @(negedge clk);
         slot    = (c - 1) / 5;
         ph      = (c - 1) % 5;
         exp_enb = (ph < 3) ? 4'(1 << (slot % 4)) : 4'b0000;
         exp_z   = 8'(8'h11 * ((slot % 4) + 1));
         checks++;
         if (bus.ENB !== exp_enb) begin
            errors++; $display("FAIL rot_enb c%0d got %b want %b", c, bus.ENB, exp_enb);
         end
         checks++;
         if ($countones(bus.ENB) > 1) begin
            errors++; $display("FAIL rot_onehot c%0d got %b want at most one bit", c, bus.ENB);
         end
         if (ph < 3) begin
            checks++;
            if (z !== exp_z) begin
               errors++; $display("FAIL rot_z c%0d got %h want %h", c, z, exp_z);
            end
         end
      end
      bus.REQ = 4'b0000;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.BUSY !== 1'b0) begin
         errors++; $display("FAIL rot_drain_busy got %b want 0", bus.BUSY);
      end
   endtask

   task automatic test_drop_at_limit(input bit req3);
      logic [3:0] exp_enb;
      logic [3:0] next_enb;
      next_enb = req3 ? 4'b1000 : 4'b0010;
      bus.REQ  = 4'b0100;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         exp_enb = (c <= 3) ? 4'b0100 : ((c == 6) ? next_enb : 4'b0000);
         checks++;
         if (bus.ENB !== exp_enb) begin
            errors++;
            $display("FAIL drop_enb r3=%0d c%0d got %b want %b", req3, c, bus.ENB, exp_enb);
         end
         if (c == 4 || c == 5) begin
            checks++;
            if (bus.BUSY !== 1'b1) begin
               errors++; $display("FAIL drop_dead_busy r3=%0d c%0d got 0 want 1", req3, c);
            end
         end
         if (c == 1) bus.REQ = 4'b0110;
         if (c == 3) bus.REQ = req3 ? 4'b1010 : 4'b0010;
      end
      checks++;
      if (bus.OWNER !== (req3 ? 2'd3 : 2'd1)) begin
         errors++; $display("FAIL drop_owner r3=%0d got %0d", req3, bus.OWNER);
      end
      bus.REQ = 4'b0000;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.BUSY !== 1'b0) begin
         errors++; $display("FAIL drop_drain_busy r3=%0d got %b want 0", req3, bus.BUSY);
      end
   endtask

   task automatic test_async_reset();
      bus.DIN = {8'h44, 8'h33, 8'h22, 8'h11};
      bus.REQ = 4'b0001;
      @(negedge clk);
      checks++;
      if (bus.ENB !== 4'b0001 || z !== 8'h11) begin
         errors++; $display("FAIL arst_pre got enb %b z %h want 0001 11", bus.ENB, z);
      end
      #2 rstb = 1'b0;
      #1;
      checks++;
      if (bus.ENB !== 4'b0000) begin
         errors++; $display("FAIL arst_enb got %b want 0000", bus.ENB);
      end
      bus.REQ = 4'b0101;
      @(negedge clk);
      rstb = 1'b1;
      #1;
      checks++;
      if (bus.GNT !== 4'b0000 || bus.OWNER !== 2'd3) begin
         errors++; $display("FAIL arst_post got gnt %b owner %0d want 0000 3", bus.GNT, bus.OWNER);
      end
      @(negedge clk);
      checks++;
      if (bus.ENB !== 4'b0001 || bus.OWNER !== 2'd0) begin
         errors++; $display("FAIL arst_first got enb %b owner %0d want 0001 0", bus.ENB, bus.OWNER);
      end
      bus.REQ = 4'b0000;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.BUSY !== 1'b0) begin
         errors++; $display("FAIL arst_drain_busy got %b want 0", bus.BUSY);
      end
   endtask

   task automatic test_keeper();
      bus.DIN[7:0] = 8'h3C;
      bus.REQ      = 4'b0001;
      @(negedge clk);
      checks++;
      if (bus.ENB !== 4'b0001 || z !== 8'h3C) begin
         errors++; $display("FAIL keep_drive got enb %b z %h want 0001 3c", bus.ENB, z);
      end
      bus.REQ = 4'b0000;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         checks++;
         if (bus.ENB !== 4'b0000) begin
            errors++; $display("FAIL keep_enb c%0d got %b want 0000", c, bus.ENB);
         end
`ifdef TNBUF_SEQ_KEEPER_EN
         checks++;
         if (z !== 8'h3C) begin
            errors++; $display("FAIL keep_z c%0d got %h want 3c", c, z);
         end
`else
         checks++;
         if (z === 8'h3C) begin
            errors++; $display("FAIL keep_z c%0d got %h want released bus", c, z);
         end
`endif
      end
      checks++;
      if (bus.BUSY !== 1'b0) begin
         errors++; $display("FAIL keep_idle_busy got %b want 0", bus.BUSY);
      end
   endtask

   initial begin
      rstb    = 1'b0;
      bus.REQ = '0;
      bus.DIN = '0;
      test_reset();
      test_single();
      test_rotation();
      test_drop_at_limit(1'b0);
      test_drop_at_limit(1'b1);
      test_async_reset();
      test_keeper();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
